// File: rtl/full_adder_if.sv
// Operand/result bundle for the ripple-carry full adder.
// The master drives the operands and carry-in and observes both the
// combinational and the registered results; the slave is the adder itself.
// There is no handshake: results are valid whenever the operands are stable
// (combinational path) or one clock edge later (registered path).
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic [WIDTH-1:0] S_q;
    logic             Cout_q;

    modport master (
        output A, B, Cin,
        input  S, Cout, S_q, Cout_q
    );

    modport slave (
        input  A, B, Cin,
        output S, Cout, S_q, Cout_q
    );
endinterface

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder: {Cout, S} = A + B + Cin.
// The combinational result is a chain of 1-bit full-adder cells with carry
// c[0] = Cin and Cout = c[WIDTH]. A registered copy of the result is kept
// for pipelined users; reset clears only that copy, never the live sum.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    full_adder_if.slave       bus
);

    logic [WIDTH-1:0] w_s;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] r_s_q;
    logic             r_cout_q;

    // Ripple chain: each cell consumes c[i] and produces s[i] and c[i+1].
    always_comb begin
        w_s    = '0;
        w_c    = '0;
        w_c[0] = bus.Cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_s[i]   = bus.A[i] ^ bus.B[i] ^ w_c[i];
            w_c[i+1] = (bus.A[i] & bus.B[i]) | (w_c[i] & (bus.A[i] ^ bus.B[i]));
        end
    end

    // Registered copy of the result, one cycle behind, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_q    <= '0;
            r_cout_q <= 1'b0;
        end else begin
            r_s_q    <= w_s;
            r_cout_q <= w_c[WIDTH];
        end
    end

    assign bus.S      = w_s;
    assign bus.Cout   = w_c[WIDTH];
    assign bus.S_q    = r_s_q;
    assign bus.Cout_q = r_cout_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH = 1, 4 and 8. Inputs change on the falling
// edge; combinational results are sampled 1 time unit later and registered
// results 1 time unit after the rising edge.
module tb_full_adder;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [8:0] exp_q[$];

    full_adder_if #(.WIDTH(1)) if_w1 ();
    full_adder_if #(.WIDTH(4)) if_w4 ();
    full_adder_if #(.WIDTH(8)) if_w8 ();

    full_adder #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .bus(if_w1));
    full_adder #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst), .bus(if_w4));
    full_adder #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .bus(if_w8));

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_all(input logic [7:0] a, input logic [7:0] b, input logic cin);
        if_w1.A   = a[0:0];
        if_w1.B   = b[0:0];
        if_w1.Cin = cin;
        if_w4.A   = a[3:0];
        if_w4.B   = b[3:0];
        if_w4.Cin = cin;
        if_w8.A   = a;
        if_w8.B   = b;
        if_w8.Cin = cin;
    endtask

    // Expected {Cout, S} for the WIDTH=1 sweep, indexed by {A,B,Cin}.
    logic [1:0] sweep_exp [8];

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] sum;
        logic [8:0] exp_reg;
        logic [2:0] vb;

        errors = 0;
        checks = 0;
        sweep_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset held for two cycles with all inputs at one.
        rst = 1'b1;
        drive_all(8'h01, 8'h01, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("rst_w1_reg", {7'd0, if_w1.Cout_q, if_w1.S_q}, 9'h000);
            check("rst_w8_reg", {if_w8.Cout_q, if_w8.S_q}, 9'h000);
            check("rst_w1_comb", {7'd0, if_w1.Cout, if_w1.S}, 9'h003);
        end

        // Latency: deassert reset and apply {1,0,1}.
        @(negedge clk);
        rst = 1'b0;
        drive_all(8'h01, 8'h00, 1'b1);
        #1;
        check("lat_comb", {7'd0, if_w1.Cout, if_w1.S}, 9'h002);
        check("lat_reg_before", {7'd0, if_w1.Cout_q, if_w1.S_q}, 9'h000);
        @(posedge clk);
        #1;
        check("lat_reg_after", {7'd0, if_w1.Cout_q, if_w1.S_q}, 9'h002);

        // Exhaustive WIDTH=1 sweep, one vector per cycle.
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            vb = v[2:0];
            drive_all({7'd0, vb[2]}, {7'd0, vb[1]}, vb[0]);
            #1;
            check("sweep_comb", {7'd0, if_w1.Cout, if_w1.S}, {7'd0, sweep_exp[v]});
            @(posedge clk);
            #1;
            check("sweep_reg", {7'd0, if_w1.Cout_q, if_w1.S_q}, {7'd0, sweep_exp[v]});
        end

        // WIDTH=4 wrap-around cases.
        @(negedge clk);
        drive_all(8'h0F, 8'h01, 1'b0);
        #1;
        check("w4_wrap_comb", {4'd0, if_w4.Cout, if_w4.S}, 9'h010);
        @(posedge clk);
        #1;
        check("w4_wrap_reg", {4'd0, if_w4.Cout_q, if_w4.S_q}, 9'h010);
        @(negedge clk);
        drive_all(8'hFF, 8'hFF, 1'b1);
        #1;
        check("w4_ones_comb", {4'd0, if_w4.Cout, if_w4.S}, 9'h01F);
        check("w8_ones_comb", {if_w8.Cout, if_w8.S}, 9'h1FF);
        @(posedge clk);
        #1;
        check("w4_ones_reg", {4'd0, if_w4.Cout_q, if_w4.S_q}, 9'h01F);
        check("w8_ones_reg", {if_w8.Cout_q, if_w8.S_q}, 9'h1FF);

        // Mid-stream reset on the WIDTH=8 instance with changing stimulus.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            cin = 1'($urandom_range(0, 1));
            rst = (k == 3);
            drive_all(a, b, cin);
            sum = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            exp_q.push_back(rst ? 9'h000 : sum);
            #1;
            check("mid_comb", {if_w8.Cout, if_w8.S}, sum);
            @(posedge clk);
            #1;
            exp_reg = exp_q.pop_front();
            check("mid_reg", {if_w8.Cout_q, if_w8.S_q}, exp_reg);
        end
        @(negedge clk);
        rst = 1'b0;

        // Random vectors at WIDTH=8 against A+B+Cin on both paths.
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            drive_all(a, b, cin);
            sum = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            exp_q.push_back(sum);
            #1;
            check("rand_comb", {if_w8.Cout, if_w8.S}, sum);
            @(posedge clk);
            #1;
            exp_reg = exp_q.pop_front();
            check("rand_reg", {if_w8.Cout_q, if_w8.S_q}, exp_reg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
